// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: debounced button levels in, one-cycle count-enable/clear pulses out.
// Saturates at 9999, keeps a lap snapshot and picks live count or lap for the display.
module stopwatch_ctrl #(
   parameter int TICK_DIV = 1_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn_ss,
   input  logic        btn_lr,
   input  logic [15:0] count_in,
   output logic        cnt_en,
   output logic        cnt_clr,
   output logic [15:0] disp,
   output logic        running,
   output logic        done,
   output logic [2:0]  state
);
   localparam int              PW        = $clog2(TICK_DIV);
   localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RUN   = 3'd1,
      S_LAP   = 3'd2,
      S_PAUSE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t        r_state, w_state_nxt;
   logic [PW-1:0] r_presc, w_presc_nxt;
   logic [15:0]   r_lap, w_lap_nxt;
   logic          r_ss_q, r_lr_q;
   logic          r_cnt_en, r_cnt_clr;
   logic          w_clr_nxt, w_en_nxt;
   logic          w_ss, w_lr, w_counting, w_tick, w_sat;

   // Start/stop wins a same-cycle tie, so lap/reset is masked here once.
   assign w_ss       = btn_ss & ~r_ss_q;
   assign w_lr       = btn_lr & ~r_lr_q & ~w_ss;
   assign w_counting = (r_state == S_RUN) || (r_state == S_LAP);
   assign w_tick     = w_counting && (r_presc == PRESC_MAX);
   assign w_sat      = (count_in == 16'h9999);
   assign w_en_nxt   = w_tick && !w_sat;

   always_comb begin
      w_state_nxt = r_state;
      w_lap_nxt   = r_lap;
      w_clr_nxt   = 1'b0;
      w_presc_nxt = r_presc;
      if (w_tick && w_sat) begin
         w_state_nxt = S_DONE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_ss)      w_state_nxt = S_RUN;
               else if (w_lr) w_clr_nxt   = 1'b1;
            end
            S_RUN: begin
               if (w_ss) begin
                  w_state_nxt = S_PAUSE;
               end else if (w_lr) begin
                  w_state_nxt = S_LAP;
                  w_lap_nxt   = count_in;
               end
            end
            S_LAP: begin
               if (w_ss)      w_state_nxt = S_PAUSE;
               else if (w_lr) w_state_nxt = S_RUN;
            end
            S_PAUSE: begin
               if (w_ss) begin
                  w_state_nxt = S_RUN;
               end else if (w_lr) begin
                  w_state_nxt = S_IDLE;
                  w_clr_nxt   = 1'b1;
               end
            end
            S_DONE: begin
               if (w_lr) begin
                  w_state_nxt = S_IDLE;
                  w_clr_nxt   = 1'b1;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
      // PAUSE keeps its phase so a resume continues mid-interval.
      if ((w_state_nxt == S_IDLE) || (w_state_nxt == S_DONE)) begin
         w_presc_nxt = '0;
      end else if (w_counting) begin
         w_presc_nxt = w_tick ? '0 : r_presc + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_presc   <= '0;
         r_lap     <= 16'h0000;
         r_ss_q    <= 1'b1;
         r_lr_q    <= 1'b1;
         r_cnt_en  <= 1'b0;
         r_cnt_clr <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_presc   <= w_presc_nxt;
         r_lap     <= w_lap_nxt;
         r_ss_q    <= btn_ss;
         r_lr_q    <= btn_lr;
         r_cnt_en  <= w_en_nxt;
         r_cnt_clr <= w_clr_nxt;
      end
   end

   assign cnt_en  = r_cnt_en;
   assign cnt_clr = r_cnt_clr;
   assign disp    = (r_state == S_LAP) ? r_lap : count_in;
   assign running = w_counting;
   assign done    = (r_state == S_DONE);
   assign state   = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios then random button/reset traffic,
// checked every cycle against an arithmetic model with a BCD counter in the loop.
module tb_stopwatch_ctrl;
   localparam int TD = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        btn_ss = 1'b0;
   logic        btn_lr = 1'b0;
   logic [15:0] count_in = 16'h0000;
   logic        cnt_en, cnt_clr, running, done;
   logic [15:0] disp;
   logic [2:0]  state;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: states numbered as the state output encodes them.
   int          m_state = 0;
   int          m_presc = 0;
   logic [15:0] m_lap   = 16'h0000;
   logic        m_en    = 1'b0;
   logic        m_clr   = 1'b0;
   logic        m_ssq   = 1'b1;
   logic        m_lrq   = 1'b1;

   stopwatch_ctrl #(.TICK_DIV(TD)) dut (
      .clk      (clk),
      .rst      (rst),
      .btn_ss   (btn_ss),
      .btn_lr   (btn_lr),
      .count_in (count_in),
      .cnt_en   (cnt_en),
      .cnt_clr  (cnt_clr),
      .disp     (disp),
      .running  (running),
      .done     (done),
      .state    (state)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      int n;
      n = 1000 * int'(v[15:12]) + 100 * int'(v[11:8]) + 10 * int'(v[7:4]) + int'(v[3:0]);
      n = (n + 1) % 10000;
      return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: predict, advance, move the counter, compare every output.
   task automatic step();
      logic        ss, lr, cnting, tick, pend_en, pend_clr, nen, nclr;
      int          ns, np;
      logic [15:0] nlap, exp_disp;
      pend_en  = m_en;
      pend_clr = m_clr;
      if (rst) begin
         ns = 0; np = 0; nlap = 16'h0000; nen = 1'b0; nclr = 1'b0;
      end else begin
         ss     = btn_ss && !m_ssq;
         lr     = btn_lr && !m_lrq && !ss;
         cnting = (m_state == 1) || (m_state == 2);
         tick   = cnting && (m_presc == TD - 1);
         nen    = tick && (count_in != 16'h9999);
         ns     = m_state;
         nlap   = m_lap;
         nclr   = 1'b0;
         if (tick && count_in == 16'h9999) begin
            ns = 4;
         end else if (ss) begin
            if (m_state == 0 || m_state == 3) ns = 1;
            else if (cnting) ns = 3;
         end else if (lr) begin
            if (m_state == 1) begin
               ns = 2; nlap = count_in;
            end else if (m_state == 2) begin
               ns = 1;
            end else begin
               ns = 0; nclr = 1'b1;
            end
         end
         np = cnting ? (m_presc + 1) % TD : m_presc;
         if (ns == 0 || ns == 4) np = 0;
      end
      @(posedge clk);
      #1;
      m_ssq   = rst ? 1'b1 : btn_ss;
      m_lrq   = rst ? 1'b1 : btn_lr;
      m_state = ns;
      m_presc = np;
      m_lap   = nlap;
      m_en    = nen;
      m_clr   = nclr;
      count_in = pend_clr ? 16'h0000 : (pend_en ? bcd_inc(count_in) : count_in);
      #1;
      exp_disp = (m_state == 2) ? m_lap : count_in;
      chk("state",   16'(state),   16'(m_state));
      chk("cnt_en",  16'(cnt_en),  16'(m_en));
      chk("cnt_clr", 16'(cnt_clr), 16'(m_clr));
      chk("disp",    disp,         exp_disp);
      chk("running", 16'(running), 16'((m_state == 1) || (m_state == 2)));
      chk("done",    16'(done),    16'(m_state == 4));
   endtask

   task automatic press_ss();
      btn_ss = 1'b1; step(); btn_ss = 1'b0;
   endtask

   task automatic press_lr();
      btn_lr = 1'b1; step(); btn_lr = 1'b0;
   endtask

   task automatic run_until(input string tag, input logic [15:0] target, input int budget);
      int k;
      k = 0;
      while (disp !== target && k < budget) begin
         step();
         k++;
      end
      chk(tag, disp, target);
   endtask

   initial begin
      logic [15:0] lapv;
      // Reset, start, first pulses
      rst = 1'b1; step(); step();
      chk("rst_state", 16'(state), 16'd0);
      chk("rst_en", 16'(cnt_en), 16'd0);
      rst = 1'b0; step();
      press_ss();
      chk("t1_running", 16'(running), 16'd1);
      repeat (3) step();
      chk("t1_no_early_en", 16'(cnt_en), 16'd0);
      step();
      chk("t1_first_en", 16'(cnt_en), 16'd1);
      repeat (4) step();
      chk("t1_second_en", 16'(cnt_en), 16'd1);
      chk("t1_cnt1", disp, 16'h0001);
      step();
      chk("t1_cnt2", disp, 16'h0002);

      // Pause and resume
      run_until("t2_reach12", 16'h0012, 100);
      press_ss();
      chk("t2_paused", 16'(state), 16'd3);
      repeat (9) step();
      chk("t2_hold_en", 16'(cnt_en), 16'd0);
      chk("t2_hold_cnt", disp, 16'h0012);
      press_ss();
      chk("t2_resumed", 16'(state), 16'd1);
      run_until("t2_reach13", 16'h0013, 20);
      press_ss();
      press_lr();
      chk("t2_clr_pulse", 16'(cnt_clr), 16'd1);
      chk("t2_idle", 16'(state), 16'd0);
      step();
      chk("t2_clr_once", 16'(cnt_clr), 16'd0);
      chk("t2_cleared", disp, 16'h0000);

      // Lap freeze and release
      press_ss();
      run_until("t3_reach7", 16'h0007, 60);
      press_lr();
      chk("t3_lap_state", 16'(state), 16'd2);
      chk("t3_frozen", disp, 16'h0007);
      repeat (10) step();
      chk("t3_still_frozen", disp, 16'h0007);
      press_lr();
      chk("t3_live", disp, count_in);

      // Lap in the cnt_en cycle keeps the pre-increment value
      for (int k = 0; k < 8 && !m_en; k++) step();
      chk("lap_align", 16'(cnt_en), 16'd1);
      lapv = count_in;
      press_lr();
      chk("lap_pre_inc", disp, lapv);
      step();
      chk("lap_hold", disp, lapv);
      press_lr();

      // Reset while in LAP
      run_until("t6_reach40", 16'h0040, 200);
      press_lr();
      chk("t6_lap", 16'(state), 16'd2);
      rst = 1'b1; step(); rst = 1'b0;
      chk("t6_idle", 16'(state), 16'd0);
      chk("t6_en", 16'(cnt_en), 16'd0);
      chk("t6_disp", disp, count_in);

      // Saturation at 9999
      step();
      count_in = 16'h9998;
      press_ss();
      repeat (10) step();
      chk("t4_done", 16'(done), 16'd1);
      chk("t4_sat", disp, 16'h9999);
      chk("t4_no_en", 16'(cnt_en), 16'd0);
      press_ss();
      chk("t4_ss_ignored", 16'(state), 16'd4);
      step();
      press_lr();
      chk("t4_clr", 16'(cnt_clr), 16'd1);
      chk("t4_idle", 16'(state), 16'd0);
      step();
      chk("t4_zero", disp, 16'h0000);
      chk("t4_clr_once", 16'(cnt_clr), 16'd0);

      // Simultaneous presses and a button held through reset
      btn_ss = 1'b1; btn_lr = 1'b1; step();
      chk("t5_run", 16'(state), 16'd1);
      chk("t5_no_clr", 16'(cnt_clr), 16'd0);
      btn_ss = 1'b0; btn_lr = 1'b0; step();
      btn_ss = 1'b1; rst = 1'b1; step(); step();
      rst = 1'b0; step(); step();
      chk("t5_held_no_press", 16'(state), 16'd0);
      btn_ss = 1'b0; step();

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) btn_ss = ~btn_ss;
         if ($urandom_range(0, 3) == 0) btn_lr = ~btn_lr;
         rst = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 149) == 0) count_in = 16'h9990 + 16'($urandom_range(0, 9));
         step();
      end
      rst = 1'b0; btn_ss = 1'b0; btn_lr = 1'b0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
